// File: rtl/strobe_scheduler_pkg.sv
// Shared definitions for the strobe scheduler: timebase sizing, FSM state encoding.
// Latency: n/a (constants and an elaboration-time helper only).
// Backpressure: n/a.
//
// Contents:
//   NS_PER_S     nanoseconds per second, used by the tick calculation
//   state_t      FSM state type, with IDLE / RUN / DONE encodings
//   delay_ticks  clock cycles per strobe period, rounded to nearest, minimum 1
package strobe_pkg;

   localparam longint unsigned NS_PER_S = 64'd1_000_000_000;

   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t DONE = 2'd2;

   // The product CLOCK_HZ * PERIOD_NS exceeds 32 bits for ordinary clock
   // rates, so the whole calculation stays in 64-bit arithmetic.
   function automatic int delay_ticks(input longint unsigned clock_hz,
                                      input longint unsigned period_ns);
      longint unsigned ticks;
      ticks = (clock_hz * period_ns + NS_PER_S / 64'd2) / NS_PER_S;
      if (ticks < 64'd1) ticks = 64'd1;
      return int'(ticks);
   endfunction

endpackage

// File: rtl/strobe_scheduler_if.sv
// Request/grant bundle between peripheral controllers and the strobe scheduler.
// Latency: n/a (wires only).
// Backpressure: requester holds Request_i high until Done_o; no other flow control.
//
// Signals:
//   Request_i  level request per channel
//   Count_i    per-channel burst length, channel k at [k*COUNT_WIDTH +: COUNT_WIDTH]
//   Grant_o    one-hot owner of the shared timebase
//   Strobe_o   single-cycle strobe to the owner
//   Done_o     single-cycle burst-complete pulse
//   Busy_o     any grant held
// Modports: master = requester side, slave = scheduler side.
interface strobe_scheduler_if #(
   parameter int CHANNELS    = 4,
   parameter int COUNT_WIDTH = 8
);
   logic [CHANNELS-1:0]             Request_i;
   logic [CHANNELS*COUNT_WIDTH-1:0] Count_i;
   logic [CHANNELS-1:0]             Grant_o;
   logic [CHANNELS-1:0]             Strobe_o;
   logic [CHANNELS-1:0]             Done_o;
   logic                            Busy_o;

   modport master (
      output Request_i, Count_i,
      input  Grant_o, Strobe_o, Done_o, Busy_o
   );

   modport slave (
      input  Request_i, Count_i,
      output Grant_o, Strobe_o, Done_o, Busy_o
   );
endinterface

// File: rtl/strobe_scheduler_timebase.sv
// Shared strobe timebase: counts 0..DELAY_TICKS-1 and flags the terminal count.
// Latency: tc is combinational from the counter; it asserts on the DELAY_TICKS-th enabled cycle after clr.
// Backpressure: none; counting pauses while en is low, clr has priority over en.
//
// Ports:
//   Clock, Reset  system clock, asynchronous active-high reset
//   clr           return the counter to 0
//   en            advance the counter
//   tc            terminal count reached this cycle (only while en)
module strobe_timebase #(
   parameter int DELAY_TICKS = 7
) (
   input  logic Clock,
   input  logic Reset,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam int CNT_W = (DELAY_TICKS > 1) ? $clog2(DELAY_TICKS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DELAY_TICKS - 1);

   logic [CNT_W-1:0] cnt;

   assign tc = en && (cnt == LAST);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + 1'b1;
      end
   end
endmodule

// File: rtl/strobe_scheduler.sv
// Shares one prescaled strobe timebase among CHANNELS requesters, one burst of N strobes at a time.
// Latency: grant 1 cycle after request seen in IDLE; strobes every DELAY_TICKS cycles; Done_o 1 cycle after last strobe.
// Backpressure: one owner at a time; other requests wait for IDLE, never pre-empt; owner dropping request aborts.
//
// Ports:
//   Clock, Reset  system clock, asynchronous active-high reset
//   bus           strobe_scheduler_if slave modport (Request_i, Count_i in; Grant_o, Strobe_o, Done_o, Busy_o out)
// Build option: STROBE_SCHEDULER_PRIORITY_EN selects fixed priority (lowest index wins)
// instead of round-robin and removes the rotation pointer.
module strobe_scheduler
   import strobe_pkg::*;
#(
   parameter longint unsigned CLOCK_HZ    = 14_000_000,
   parameter longint unsigned PERIOD_NS   = 500,
   parameter int              CHANNELS    = 4,
   parameter int              COUNT_WIDTH = 8
) (
   input  logic               Clock,
   input  logic               Reset,
   strobe_scheduler_if.slave  bus
);
   localparam int DELAY_TICKS = delay_ticks(CLOCK_HZ, PERIOD_NS);
   localparam int IDX_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   state_t                 state;
   logic [IDX_W-1:0]       winner;
   logic [COUNT_WIDTH-1:0] remaining;
   logic [CHANNELS-1:0]    grant;
   logic [CHANNELS-1:0]    strobe;
   logic [CHANNELS-1:0]    done;

   logic [IDX_W-1:0]       start;
   logic [IDX_W-1:0]       pick;
   logic                   pick_vld;
   logic [COUNT_WIDTH-1:0] pick_count;
   int                     sel_idx;

   logic                   owner_req;
   logic                   abort;
   logic                   tb_clr;
   logic                   tb_en;
   logic                   tb_tc;

   assign owner_req = bus.Request_i[winner];
   assign abort     = (state == RUN) && !owner_req;

   // ---------------------------------------------------------------
   // Arbitration start point
   // ---------------------------------------------------------------
`ifdef STROBE_SCHEDULER_PRIORITY_EN
   assign start = '0;
`else
   logic [IDX_W-1:0] ptr;

   // The pointer moves past the owner whenever its burst ends, whether it
   // completed or was abandoned, so a flaky requester cannot hog the timebase.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         ptr <= '0;
      end else if ((state == DONE) || abort) begin
         ptr <= (int'(winner) == CHANNELS - 1) ? '0 : winner + 1'b1;
      end
   end

   assign start = ptr;
`endif

   // Scan from the highest offset down so the channel nearest to start is
   // the last assignment and therefore the winner.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      sel_idx  = 0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         sel_idx = int'(start) + i;
         if (sel_idx >= CHANNELS) sel_idx = sel_idx - CHANNELS;
         if (bus.Request_i[sel_idx]) begin
            pick     = IDX_W'(sel_idx);
            pick_vld = 1'b1;
         end
      end
   end

   assign pick_count = bus.Count_i[int'(pick)*COUNT_WIDTH +: COUNT_WIDTH];

   // ---------------------------------------------------------------
   // Shared timebase: held at 0 outside RUN so the first strobe lands
   // exactly DELAY_TICKS cycles after the grant edge.
   // ---------------------------------------------------------------
   assign tb_clr = (state != RUN);
   assign tb_en  = (state == RUN) && owner_req;

   strobe_timebase #(
      .DELAY_TICKS (DELAY_TICKS)
   ) u_timebase (
      .Clock (Clock),
      .Reset (Reset),
      .clr   (tb_clr),
      .en    (tb_en),
      .tc    (tb_tc)
   );

   // ---------------------------------------------------------------
   // Burst FSM
   // DONE raises Done_o and returns to IDLE with the grant still held;
   // that first IDLE cycle retires the grant (Done_o and Grant_o fall on
   // the same edge), which also gives the one idle cycle between bursts.
   // ---------------------------------------------------------------
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         winner    <= '0;
         remaining <= '0;
         grant     <= '0;
         strobe    <= '0;
         done      <= '0;
      end else begin
         strobe <= '0;
         done   <= '0;
         case (state)
            IDLE: begin
               if (|grant) begin
                  grant <= '0;
               end else if (pick_vld) begin
                  winner    <= pick;
                  grant     <= CHANNELS'(1) << pick;
                  remaining <= pick_count;
                  state     <= (pick_count == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               if (!owner_req) begin
                  grant <= '0;
                  state <= IDLE;
               end else if (tb_tc) begin
                  strobe[winner] <= 1'b1;
                  remaining      <= remaining - 1'b1;
                  if (remaining == COUNT_WIDTH'(1)) state <= DONE;
               end
            end
            DONE: begin
               done[winner] <= 1'b1;
               state        <= IDLE;
            end
            default: begin
               grant <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.Grant_o  = grant;
   assign bus.Strobe_o = strobe;
   assign bus.Done_o   = done;
   assign bus.Busy_o   = |grant;

endmodule

// File: tb/tb_strobe_scheduler.sv
// Directed bench for strobe_scheduler at default parameters (DELAY_TICKS = 7).
// Latency: n/a.
// Backpressure: n/a.
module tb_strobe_scheduler;
   localparam int CH = 4;
   localparam int CW = 8;

`ifdef STROBE_SCHEDULER_PRIORITY_EN
   localparam logic [3:0] SECOND = 4'b0001;
`else
   localparam logic [3:0] SECOND = 4'b0100;
`endif

   logic Clock = 1'b0;
   logic Reset = 1'b1;

   int vectors     = 0;
   int miscompares = 0;

   strobe_scheduler_if #(.CHANNELS(CH), .COUNT_WIDTH(CW)) bus ();

   strobe_scheduler #(
      .CLOCK_HZ    (14_000_000),
      .PERIOD_NS   (500),
      .CHANNELS    (CH),
      .COUNT_WIDTH (CW)
   ) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clock = ~Clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic [3:0] g, input logic [3:0] s,
                             input logic [3:0] d);
      check_vec({tag, " grant"},  32'(bus.Grant_o),  32'(g));
      check_vec({tag, " strobe"}, 32'(bus.Strobe_o), 32'(s));
      check_vec({tag, " done"},   32'(bus.Done_o),   32'(d));
      check_vec({tag, " busy"},   32'(bus.Busy_o),   32'(g != 4'b0000));
   endtask

   task automatic apply_reset();
      Reset         = 1'b1;
      bus.Request_i = '0;
      bus.Count_i   = '0;
      tick();
      tick();
      Reset = 1'b0;
      tick();
   endtask

   initial begin
      logic [3:0] eg, es, ed;
      int         nstb;
      int         n;
      logic       done_seen;
      logic       stray;

      bus.Request_i = '0;
      bus.Count_i   = '0;
      #1;
      check_outs("reset", 4'b0000, 4'b0000, 4'b0000);
      apply_reset();

      // 1: channel 1, count 3; Count_i rewritten after grant must not matter
      bus.Count_i[1*CW +: CW] = 8'd3;
      bus.Request_i = 4'b0010;
      #1;
      check_vec("t1 grant before edge", 32'(bus.Grant_o), 32'h0);
      tick();
      for (int k = 0; k <= 24; k++) begin
         eg = (k <= 22) ? 4'b0010 : 4'b0000;
         es = (k == 7 || k == 14 || k == 21) ? 4'b0010 : 4'b0000;
         ed = (k == 22) ? 4'b0010 : 4'b0000;
         check_outs($sformatf("t1 k%0d", k), eg, es, ed);
         if (k == 2)  bus.Count_i[1*CW +: CW] = 8'd9;
         if (k == 22) bus.Request_i = 4'b0000;
         tick();
      end

      // 2: channels 0 and 2 held with count 1 each, pointer fresh from reset
      apply_reset();
      bus.Count_i[0*CW +: CW] = 8'd1;
      bus.Count_i[2*CW +: CW] = 8'd1;
      bus.Request_i = 4'b0101;
      tick();
      for (int k = 0; k <= 30; k++) begin
         if (k <= 8)       eg = 4'b0001;
         else if (k == 9)  eg = 4'b0000;
         else if (k <= 18) eg = SECOND;
         else if (k == 19) eg = 4'b0000;
         else if (k <= 28) eg = 4'b0001;
         else              eg = 4'b0000;
         es = (k == 7 || k == 27) ? 4'b0001 : (k == 17) ? SECOND : 4'b0000;
         ed = (k == 8 || k == 28) ? 4'b0001 : (k == 18) ? SECOND : 4'b0000;
         check_outs($sformatf("t2 k%0d", k), eg, es, ed);
         if (k == 28) bus.Request_i = 4'b0000;
         tick();
      end

      // 3: channel 3, count 0 -> grant, then done, no strobe
      bus.Count_i[3*CW +: CW] = 8'd0;
      bus.Request_i = 4'b1000;
      tick();
      for (int k = 0; k <= 3; k++) begin
         eg = (k <= 1) ? 4'b1000 : 4'b0000;
         ed = (k == 1) ? 4'b1000 : 4'b0000;
         check_outs($sformatf("t3 k%0d", k), eg, 4'b0000, ed);
         if (k == 1) bus.Request_i = 4'b0000;
         tick();
      end

      // 4: channel 0 count 5 aborted after 2 strobes, channel 1 pending,
      //    then reset lands on channel 1's first strobe
      bus.Count_i[0*CW +: CW] = 8'd5;
      bus.Count_i[1*CW +: CW] = 8'd2;
      bus.Request_i = 4'b0011;
      tick();
      for (int k = 0; k <= 23; k++) begin
         eg = (k <= 14) ? 4'b0001 : (k == 15) ? 4'b0000 : 4'b0010;
         es = (k == 7 || k == 14) ? 4'b0001 : (k == 23) ? 4'b0010 : 4'b0000;
         check_outs($sformatf("t4 k%0d", k), eg, es, 4'b0000);
         if (k == 14) bus.Request_i = 4'b0010;
         if (k < 23) tick();
      end
      Reset = 1'b1;
      #1;
      check_outs("t4 async reset", 4'b0000, 4'b0000, 4'b0000);
      bus.Request_i = 4'b0000;
      tick();
      tick();
      Reset = 1'b0;
      tick();

      // 5: after reset the pointer is back at 0: channel 0 beats channel 1
      bus.Count_i[0*CW +: CW] = 8'd0;
      bus.Count_i[1*CW +: CW] = 8'd0;
      bus.Request_i = 4'b0011;
      tick();
      for (int k = 0; k <= 2; k++) begin
         eg = (k <= 1) ? 4'b0001 : 4'b0000;
         ed = (k == 1) ? 4'b0001 : 4'b0000;
         check_outs($sformatf("t5 k%0d", k), eg, 4'b0000, ed);
         if (k == 1) bus.Request_i = 4'b0000;
         tick();
      end

      // 6: maximum count on channel 2 delivers exactly 255 strobes
      bus.Count_i[2*CW +: CW] = 8'd255;
      bus.Request_i = 4'b0100;
      nstb      = 0;
      n         = 0;
      done_seen = 1'b0;
      stray     = 1'b0;
      while (!done_seen && n < 2500) begin
         tick();
         n++;
         if (bus.Strobe_o[2]) nstb++;
         if ((bus.Strobe_o & 4'b1011) != 4'b0000) stray = 1'b1;
         if (bus.Done_o[2]) done_seen = 1'b1;
      end
      check_vec("t6 done seen", 32'(done_seen), 32'd1);
      check_vec("t6 strobe count", 32'(nstb), 32'd255);
      check_vec("t6 stray strobes", 32'(stray), 32'd0);
      check_vec("t6 cycles to done", 32'(n), 32'(1 + 255 * 7 + 1));
      bus.Request_i = 4'b0000;
      tick();
      tick();
      check_outs("t6 idle", 4'b0000, 4'b0000, 4'b0000);

`ifdef STROBE_SCHEDULER_PRIORITY_EN
      // 7: fixed priority keeps channel 0 ahead of channel 1 every burst
      bus.Count_i[0*CW +: CW] = 8'd0;
      bus.Count_i[1*CW +: CW] = 8'd0;
      bus.Request_i = 4'b0011;
      tick();
      for (int k = 0; k < 12; k++) begin
         eg = ((k % 3) == 2) ? 4'b0000 : 4'b0001;
         check_vec($sformatf("t7 k%0d grant", k), 32'(bus.Grant_o), 32'(eg));
         tick();
      end
      bus.Request_i = 4'b0000;
      tick();
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
